// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bundle for sync_fifo_prog; names are from the FIFO's point of view
// (_i drives into the FIFO, _o comes out of it).
interface sync_fifo_prog_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             en_i;
  logic             we_i;
  logic             re_i;
  logic             flush_i;
  logic             clear_err_i;
  logic [WIDTH-1:0] write_data_i;
  logic [CW-1:0]    af_thresh_i;
  logic [CW-1:0]    ae_thresh_i;
  logic [WIDTH-1:0] read_data_o;
  logic [CW-1:0]    count_o;
  logic             full_o;
  logic             empty_o;
  logic             half_empty_o;
  logic             almost_full_o;
  logic             almost_empty_o;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output en_i, we_i, re_i, flush_i, clear_err_i, write_data_i, af_thresh_i, ae_thresh_i,
    input  read_data_o, count_o, full_o, empty_o, half_empty_o, almost_full_o,
           almost_empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  en_i, we_i, re_i, flush_i, clear_err_i, write_data_i, af_thresh_i, ae_thresh_i,
    output read_data_o, count_o, full_o, empty_o, half_empty_o, almost_full_o,
           almost_empty_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags, flush and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise Read_Data is registered.
module sync_fifo_prog #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  sync_fifo_prog_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full, empty, rd_acc, wr_acc, ovf_set, udf_set;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    rd_acc  = bus.en_i & bus.re_i & ~empty;
    // A read in the same cycle frees a slot, so a full FIFO can still accept
    wr_acc  = bus.en_i & bus.we_i & (~full | rd_acc);
    ovf_set = ~bus.flush_i & bus.en_i & bus.we_i & full & ~rd_acc;
    udf_set = ~bus.flush_i & bus.en_i & bus.re_i & empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc & ~rd_acc)      count_d = count_q + CW'(1);
      else if (rd_acc & ~wr_acc) count_d = count_q - CW'(1);
    end

    // A fresh error in the clearing cycle wins over the clear
    ovf_d = ovf_set | (ovf_q & ~bus.clear_err_i);
    udf_d = udf_set | (udf_q & ~bus.clear_err_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc & ~bus.flush_i) mem_q[wr_ptr_q] <= bus.write_data_i;
  end

`ifdef FIFO_FWFT_EN
  assign bus.read_data_o = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Read port captures the head word; held across flushes and idle cycles
  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc & ~bus.flush_i) rdata_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign bus.read_data_o = rdata_q;
`endif

  assign bus.count_o        = count_q;
  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.half_empty_o   = (count_q <= CW'(DEPTH / 2));
  assign bus.almost_full_o  = (count_q >= bus.af_thresh_i);
  assign bus.almost_empty_o = (count_q <= bus.ae_thresh_i);
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = udf_q;
endmodule
